// File: rtl/i2c_target.sv
// i2c_target: MPU-6050 style I2C responder with a 16-byte
// host-loadable register window and auto-incrementing pointer.
module i2c_target #(
   parameter logic [6:0] DEV_ADDR    = 7'h68,
   parameter logic [7:0] BASE_ADDR   = 8'h3B,
   parameter logic [7:0] WHOAMI_ADDR = 8'h75,
   parameter logic [7:0] WHOAMI_VAL  = 8'h68
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       busy,
   input  logic       load_en,
   input  logic [3:0] load_addr,
   input  logic [7:0] load_data,
   output logic       wr_valid,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ACK_A, REG, ACK_R, WR, ACK_W, RD, RACK
   } state_t;

   state_t     state, state_n;
   logic [1:0] scl_sync, sda_sync;
   logic       scl_d, sda_d, sda_s;
   logic       scl_rise, scl_fall, start_c, stop_c;
   logic [2:0] cnt, cnt_n;
   logic [7:0] rx_sh, rx_n, rx_byte;
   logic [7:0] tx_sh, tx_n;
   logic [7:0] ptr, ptr_n;
   logic [7:0] rd_idx, rd_byte;
   logic       in_win;
   logic       rw, rw_n, busy_n;
   logic       wr_valid_n, win_we;
   logic [7:0] wr_addr_n, wr_data_n;
   logic       fall_q, oe_calc;
   logic [7:0] win [16];

   // Synchronizers idle high so reset release never fakes a bus edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[0], scl};
         sda_sync <= {sda_sync[0], sda_in};
         scl_d    <= scl_sync[1];
         sda_d    <= sda_sync[1];
      end
   end

   assign sda_s    = sda_sync[1];
   assign scl_rise = scl_sync[1] & ~scl_d;
   assign scl_fall = ~scl_sync[1] & scl_d;
   assign start_c  = scl_sync[1] & scl_d & sda_d & ~sda_s;
   assign stop_c   = scl_sync[1] & scl_d & ~sda_d & sda_s;
   assign rx_byte  = {rx_sh[6:0], sda_s};

   assign rd_idx = ptr - BASE_ADDR;
   assign in_win = rd_idx < 8'd16;

   always_comb begin
      rd_byte = 8'h00;
      if (in_win)
         rd_byte = win[rd_idx[3:0]];
      else if (ptr == WHOAMI_ADDR)
         rd_byte = WHOAMI_VAL;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         rx_sh    <= '0;
         tx_sh    <= '0;
         ptr      <= '0;
         rw       <= 1'b0;
         busy     <= 1'b0;
         wr_valid <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         rx_sh    <= rx_n;
         tx_sh    <= tx_n;
         ptr      <= ptr_n;
         rw       <= rw_n;
         busy     <= busy_n;
         wr_valid <= wr_valid_n;
         wr_addr  <= wr_addr_n;
         wr_data  <= wr_data_n;
      end
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      rx_n       = rx_sh;
      tx_n       = tx_sh;
      ptr_n      = ptr;
      rw_n       = rw;
      busy_n     = busy;
      wr_valid_n = 1'b0;
      wr_addr_n  = wr_addr;
      wr_data_n  = wr_data;
      win_we     = 1'b0;
      if (stop_c) begin
         state_n = IDLE;
         busy_n  = 1'b0;
      end else if (start_c) begin
         state_n = ADDR;
         cnt_n   = '0;
      end else begin
         case (state)
            ADDR: if (scl_rise) begin
               rx_n  = rx_byte;
               cnt_n = cnt + 3'd1;
               if (cnt == 3'd7) begin
                  cnt_n = '0;
                  if (rx_byte[7:1] == DEV_ADDR) begin
                     state_n = ACK_A;
                     rw_n    = rx_byte[0];
                     busy_n  = 1'b1;
                  end else begin
                     state_n = IDLE;
                     busy_n  = 1'b0;
                  end
               end
            end
            ACK_A: begin
               if (scl_rise) begin
                  cnt_n = 3'd1;
               end else if (scl_fall && cnt == 3'd1) begin
                  cnt_n = '0;
                  if (rw) begin
                     state_n = RD;
                     tx_n    = rd_byte;
                  end else begin
                     state_n = REG;
                  end
               end
            end
            REG: if (scl_rise) begin
               rx_n  = rx_byte;
               cnt_n = cnt + 3'd1;
               if (cnt == 3'd7) begin
                  cnt_n   = '0;
                  ptr_n   = rx_byte;
                  state_n = ACK_R;
               end
            end
            ACK_R, ACK_W: begin
               if (scl_rise) begin
                  cnt_n = 3'd1;
               end else if (scl_fall && cnt == 3'd1) begin
                  cnt_n   = '0;
                  state_n = WR;
               end
            end
            WR: if (scl_rise) begin
               rx_n  = rx_byte;
               cnt_n = cnt + 3'd1;
               if (cnt == 3'd7) begin
                  cnt_n      = '0;
                  wr_valid_n = 1'b1;
                  wr_addr_n  = ptr;
                  wr_data_n  = rx_byte;
                  win_we     = 1'b1;
                  ptr_n      = ptr + 8'd1;
                  state_n    = ACK_W;
               end
            end
            RD: begin
               if (scl_rise) begin
                  cnt_n = cnt + 3'd1;
                  if (cnt == 3'd7) begin
                     cnt_n   = '0;
                     state_n = RACK;
                  end
               end else if (scl_fall) begin
                  tx_n = {tx_sh[6:0], 1'b0};
               end
            end
            RACK: begin
               // Pointer advances per byte sent, ACKed or not
               if (scl_rise && cnt == 3'd0) begin
                  ptr_n = ptr + 8'd1;
                  if (sda_s) begin
                     state_n = IDLE;
                     busy_n  = 1'b0;
                  end else begin
                     cnt_n = 3'd1;
                  end
               end else if (scl_fall && cnt == 3'd1) begin
                  cnt_n   = '0;
                  state_n = RD;
                  tx_n    = rd_byte;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      oe_calc = 1'b0;
      case (state)
         ACK_A, ACK_R, ACK_W: oe_calc = 1'b1;
         RD:                  oe_calc = ~tx_sh[7];
         default:             oe_calc = 1'b0;
      endcase
   end

   // SDA only moves one cycle after the fall has been acted on
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fall_q <= 1'b0;
         sda_oe <= 1'b0;
      end else begin
         fall_q <= scl_fall;
         if (fall_q)
            sda_oe <= oe_calc;
      end
   end

   // Bus write is applied after host load so it wins on a collision
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win <= '{default: 8'h00};
      end else begin
         if (load_en)
            win[load_addr] <= load_data;
         if (win_we && in_win)
            win[rd_idx[3:0]] <= rx_byte;
      end
   end

endmodule
